// File: rtl/rf_writeback_arbiter.sv
// Register-file write-side initiator: buffers ALU0/ALU1/MEM results in per-source
// FIFOs and round-robin arbitrates them onto the two register-file write ports.
module rf_writeback_arbiter #(
  parameter  int NUM_P_REGS = 64,
  parameter  int WORD_SIZE  = 32,
  parameter  int FIFO_DEPTH = 2,
  localparam int PW         = $clog2(NUM_P_REGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 res_valid0_i,
  output logic                 res_ready0_o,
  input  logic [PW-1:0]        res_dest0_i,
  input  logic [WORD_SIZE-1:0] res_word0_i,
  input  logic                 res_valid1_i,
  output logic                 res_ready1_o,
  input  logic [PW-1:0]        res_dest1_i,
  input  logic [WORD_SIZE-1:0] res_word1_i,
  input  logic                 res_valid2_i,
  output logic                 res_ready2_o,
  input  logic [PW-1:0]        res_dest2_i,
  input  logic [WORD_SIZE-1:0] res_word2_i,
  output logic                 reg_write0_o,
  output logic [PW-1:0]        dest0_o,
  output logic [WORD_SIZE-1:0] word0_o,
  output logic                 reg_write1_o,
  output logic [PW-1:0]        dest1_o,
  output logic [WORD_SIZE-1:0] word1_o,
  output logic                 pending_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NS = 3;

  logic                 in_valid_s [NS];
  logic [PW-1:0]        in_dest_s  [NS];
  logic [WORD_SIZE-1:0] in_word_s  [NS];
  logic                 ready_s    [NS];
  logic                 nonempty_s [NS];
  logic                 push_s     [NS];
  logic                 pop_s      [NS];
  logic [PW-1:0]        head_dest_s[NS];
  logic [WORD_SIZE-1:0] head_word_s[NS];

  logic [PW-1:0]        mem_dest_r [NS][FIFO_DEPTH];
  logic [WORD_SIZE-1:0] mem_word_r [NS][FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r   [NS];
  logic [AW-1:0]        rd_ptr_r   [NS];
  logic [AW:0]          count_r    [NS];
  logic [1:0]           rr_ptr_r;

  logic                 g0_v_s;
  logic                 g1_v_s;
  logic [1:0]           g0_idx_s;
  logic [1:0]           g1_idx_s;
  logic [1:0]           scan_idx_s;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  endfunction

  assign in_valid_s[0] = res_valid0_i;
  assign in_valid_s[1] = res_valid1_i;
  assign in_valid_s[2] = res_valid2_i;
  assign in_dest_s[0]  = res_dest0_i;
  assign in_dest_s[1]  = res_dest1_i;
  assign in_dest_s[2]  = res_dest2_i;
  assign in_word_s[0]  = res_word0_i;
  assign in_word_s[1]  = res_word1_i;
  assign in_word_s[2]  = res_word2_i;
  assign res_ready0_o  = ready_s[0];
  assign res_ready1_o  = ready_s[1];
  assign res_ready2_o  = ready_s[2];
  assign pending_o     = nonempty_s[0] | nonempty_s[1] | nonempty_s[2];

  // Per-source FIFO status and heads; results for p0 are acknowledged but dropped.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      ready_s[s]     = (count_r[s] < (AW+1)'(FIFO_DEPTH));
      nonempty_s[s]  = (count_r[s] != {(AW+1){1'b0}});
      head_dest_s[s] = mem_dest_r[s][rd_ptr_r[s]];
      head_word_s[s] = mem_word_r[s][rd_ptr_r[s]];
      push_s[s]      = in_valid_s[s] && ready_s[s] && (in_dest_s[s] != {PW{1'b0}});
    end
  end

  // Round-robin scan: first non-empty source takes port 0, next one with a distinct dest takes port 1.
  always_comb begin
    g0_v_s     = 1'b0;
    g1_v_s     = 1'b0;
    g0_idx_s   = 2'd0;
    g1_idx_s   = 2'd0;
    scan_idx_s = 2'd0;
    for (int k = 0; k < NS; k++) begin
      scan_idx_s = mod3_add(rr_ptr_r, 2'(k));
      if (nonempty_s[scan_idx_s] && !g0_v_s) begin
        g0_v_s   = 1'b1;
        g0_idx_s = scan_idx_s;
      end else if (nonempty_s[scan_idx_s] && !g1_v_s &&
                   (head_dest_s[scan_idx_s] != head_dest_s[g0_idx_s])) begin
        g1_v_s   = 1'b1;
        g1_idx_s = scan_idx_s;
      end else begin
        g1_v_s   = g1_v_s;
      end
    end
    for (int s = 0; s < NS; s++) begin
      pop_s[s] = (g0_v_s && (g0_idx_s == 2'(s))) || (g1_v_s && (g1_idx_s == 2'(s)));
    end
  end

  // FIFO storage; contents are don't-care until the matching count covers them.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NS; s++) begin
      if (push_s[s]) begin
        mem_dest_r[s][wr_ptr_r[s]] <= in_dest_s[s];
        mem_word_r[s][wr_ptr_r[s]] <= in_word_s[s];
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < NS; s++) begin
        wr_ptr_r[s] <= {AW{1'b0}};
        rd_ptr_r[s] <= {AW{1'b0}};
        count_r[s]  <= {(AW+1){1'b0}};
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (push_s[s]) wr_ptr_r[s] <= wr_ptr_r[s] + {{(AW-1){1'b0}}, 1'b1};
        if (pop_s[s])  rd_ptr_r[s] <= rd_ptr_r[s] + {{(AW-1){1'b0}}, 1'b1};
        case ({push_s[s], pop_s[s]})
          2'b10:   count_r[s] <= count_r[s] + {{AW{1'b0}}, 1'b1};
          2'b01:   count_r[s] <= count_r[s] - {{AW{1'b0}}, 1'b1};
          default: count_r[s] <= count_r[s];
        endcase
      end
    end
  end

  // Registered write ports and round-robin pointer; dest/word hold while idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_write0_o <= 1'b0;
      reg_write1_o <= 1'b0;
      dest0_o      <= {PW{1'b0}};
      dest1_o      <= {PW{1'b0}};
      word0_o      <= {WORD_SIZE{1'b0}};
      word1_o      <= {WORD_SIZE{1'b0}};
      rr_ptr_r     <= 2'd0;
    end else begin
      reg_write0_o <= g0_v_s;
      reg_write1_o <= g1_v_s;
      if (g0_v_s) begin
        dest0_o <= head_dest_s[g0_idx_s];
        word0_o <= head_word_s[g0_idx_s];
      end
      if (g1_v_s) begin
        dest1_o <= head_dest_s[g1_idx_s];
        word1_o <= head_word_s[g1_idx_s];
      end
      if (g1_v_s)      rr_ptr_r <= mod3_add(g1_idx_s, 2'd1);
      else if (g0_v_s) rr_ptr_r <= mod3_add(g0_idx_s, 2'd1);
      else             rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios plus randomized
// streaming compared against a queue-based reference model.
module tb_rf_writeback_arbiter;

  localparam int PW    = 6;
  localparam int WS    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  logic          v   [3];
  logic [PW-1:0] d   [3];
  logic [WS-1:0] w   [3];
  logic          rdy [3];
  logic we0, we1, pend;
  logic [PW-1:0] d0, d1;
  logic [WS-1:0] w0, w1;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [PW+WS-1:0] mq [3][$];
  int               m_rr;
  bit               e_we0, e_we1;
  logic [PW-1:0]    e_d0, e_d1;
  logic [WS-1:0]    e_w0, e_w1;
  bit               acc [3];
  bit               saw_full;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(.NUM_P_REGS(64), .WORD_SIZE(WS), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .res_valid0_i(v[0]), .res_ready0_o(rdy[0]), .res_dest0_i(d[0]), .res_word0_i(w[0]),
    .res_valid1_i(v[1]), .res_ready1_o(rdy[1]), .res_dest1_i(d[1]), .res_word1_i(w[1]),
    .res_valid2_i(v[2]), .res_ready2_o(rdy[2]), .res_dest2_i(d[2]), .res_word2_i(w[2]),
    .reg_write0_o(we0), .dest0_o(d0), .word0_o(w0),
    .reg_write1_o(we1), .dest1_o(d1), .word1_o(w1),
    .pending_o(pend)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    bit any;
    any = 1'b0;
    check_val("we0", we0, e_we0);
    check_val("dest0", d0, e_d0);
    check_val("word0", w0, e_w0);
    check_val("we1", we1, e_we1);
    check_val("dest1", d1, e_d1);
    check_val("word1", w1, e_w1);
    for (int s = 0; s < 3; s++) begin
      check_val($sformatf("ready%0d", s), rdy[s], mq[s].size() < DEPTH);
      if (mq[s].size() != 0) any = 1'b1;
    end
    check_val("pending", pend, any);
  endtask

  function automatic logic [PW-1:0] head_dest(input int s);
    logic [PW+WS-1:0] e;
    e = mq[s][0];
    return e[PW+WS-1:WS];
  endfunction

  function automatic logic [WS-1:0] head_word(input int s);
    logic [PW+WS-1:0] e;
    e = mq[s][0];
    return e[WS-1:0];
  endfunction

  // Advance one clock: update the model from current inputs, then check at negedge.
  task automatic step();
    int g0, g1, s;
    g0 = -1;
    g1 = -1;
    for (int k = 0; k < 3; k++) begin
      s = (m_rr + k) % 3;
      if (mq[s].size() != 0) begin
        if (g0 < 0) g0 = s;
        else if (g1 < 0 && head_dest(s) != head_dest(g0)) g1 = s;
      end
    end
    for (int i = 0; i < 3; i++) acc[i] = v[i] && (mq[i].size() < DEPTH);
    e_we0 = (g0 >= 0);
    e_we1 = (g1 >= 0);
    if (g0 >= 0) begin e_d0 = head_dest(g0); e_w0 = head_word(g0); end
    if (g1 >= 0) begin e_d1 = head_dest(g1); e_w1 = head_word(g1); end
    if (g1 >= 0)      m_rr = (g1 + 1) % 3;
    else if (g0 >= 0) m_rr = (g0 + 1) % 3;
    if (g0 >= 0) void'(mq[g0].pop_front());
    if (g1 >= 0) void'(mq[g1].pop_front());
    for (int i = 0; i < 3; i++)
      if (acc[i] && d[i] != '0) mq[i].push_back({d[i], w[i]});
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic model_reset();
    for (int s = 0; s < 3; s++) mq[s].delete();
    m_rr = 0;
    e_we0 = 0; e_we1 = 0; e_d0 = '0; e_d1 = '0; e_w0 = '0; e_w1 = '0;
  endtask

  task automatic idle_inputs();
    for (int s = 0; s < 3; s++) begin v[s] = 1'b0; d[s] = '0; w[s] = '0; acc[s] = 1'b0; end
  endtask

  // Randomized streaming; held sources keep payload until accepted.
  task automatic random_run(input int cycles, input bit src0_always, input int dmax);
    for (int c = 0; c < cycles; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (!(v[s] && !acc[s])) begin
          v[s] = (s == 0 && src0_always) ? 1'b1 : ($urandom_range(0, 3) != 0);
          d[s] = PW'($urandom_range(0, dmax));
          w[s] = $urandom;
        end
      end
      step();
      if (!rdy[0]) saw_full = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    saw_full = 1'b0;
    idle_inputs();
    model_reset();
    #12 rst = 1'b0;
    @(negedge clk);
    check_all();

    // single push on src0
    v[0] = 1'b1; d[0] = 6'd5; w[0] = 32'h11;
    step();
    idle_inputs();
    step();
    check_val("t1_we0", we0, 1'b1);
    check_val("t1_dest0", d0, 6'd5);
    check_val("t1_word0", w0, 32'h11);
    check_val("t1_we1", we1, 1'b0);
    check_val("t1_pending", pend, 1'b0);

    // walk rr_ptr back to 0 via a lone src2 grant
    v[2] = 1'b1; d[2] = 6'd1; w[2] = 32'h0;
    step();
    idle_inputs();
    step();

    // three sources at once, rr_ptr = 0
    v[0] = 1'b1; d[0] = 6'd3; w[0] = 32'hA;
    v[1] = 1'b1; d[1] = 6'd4; w[1] = 32'hB;
    v[2] = 1'b1; d[2] = 6'd7; w[2] = 32'hC;
    step();
    idle_inputs();
    step();
    check_val("t2_c1_dest0", d0, 6'd3);
    check_val("t2_c1_word0", w0, 32'hA);
    check_val("t2_c1_we1", we1, 1'b1);
    check_val("t2_c1_dest1", d1, 6'd4);
    check_val("t2_c1_word1", w1, 32'hB);
    step();
    check_val("t2_c2_we0", we0, 1'b1);
    check_val("t2_c2_dest0", d0, 6'd7);
    check_val("t2_c2_word0", w0, 32'hC);
    check_val("t2_c2_we1", we1, 1'b0);

    // move rr_ptr to 1, then same-dest conflict on src1/src2
    v[0] = 1'b1; d[0] = 6'd2; w[0] = 32'h5;
    step();
    idle_inputs();
    step();
    v[1] = 1'b1; d[1] = 6'd9; w[1] = 32'h1;
    v[2] = 1'b1; d[2] = 6'd9; w[2] = 32'h2;
    step();
    idle_inputs();
    step();
    check_val("t3_c1_dest0", d0, 6'd9);
    check_val("t3_c1_word0", w0, 32'h1);
    check_val("t3_c1_we1", we1, 1'b0);
    step();
    check_val("t3_c2_we0", we0, 1'b1);
    check_val("t3_c2_word0", w0, 32'h2);

    // dest 0 is accepted but never written
    v[2] = 1'b1; d[2] = 6'd0; w[2] = 32'hFF;
    step();
    check_val("t4_pending", pend, 1'b0);
    idle_inputs();
    step();
    check_val("t4_we0", we0, 1'b0);
    check_val("t4_we1", we1, 1'b0);

    // backpressure with src0 streaming every cycle, then free-running random traffic
    random_run(200, 1'b1, 7);
    check_val("bp_full_seen", saw_full, 1'b1);
    random_run(200, 1'b0, 63);

    // fill all FIFOs and reset asynchronously mid-stream
    for (int c = 0; c < 8; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (!(v[s] && !acc[s])) begin
          v[s] = 1'b1;
          d[s] = PW'($urandom_range(1, 63));
          w[s] = $urandom;
        end
      end
      step();
    end
    #2 rst = 1'b1;
    #1;
    check_val("rst_we0", we0, 1'b0);
    check_val("rst_we1", we1, 1'b0);
    check_val("rst_dest0", d0, 6'd0);
    check_val("rst_word1", w1, 32'd0);
    check_val("rst_pending", pend, 1'b0);
    idle_inputs();
    model_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_all();
    for (int c = 0; c < 3; c++) step();
    random_run(40, 1'b0, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side initiator for the physical register file.
- Collects completed results from three functional-unit result ports: ALU0 (src 0), ALU1 (src 1) and MEM (src 2).
- Buffers each source in a small FIFO and round-robin arbitrates onto the register file's two write ports, at most two writes per cycle.
- Registered outputs connect directly to reg_write0/1, dest0/1 and word0/1 of the register file.

Parameters:
- NUM_P_REGS, 64, number of physical registers; dest width PW = $clog2(NUM_P_REGS).
- WORD_SIZE, 32, data word width.
- FIFO_DEPTH, 2, entries per source FIFO; power of two, at least 2.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- res_valid{s}_i  in  1  source s (s = 0..2) presents a result.
- res_ready{s}_o  out  1  source s FIFO can accept.
- res_dest{s}_i  in  PW  destination physical register.
- res_word{s}_i  in  WORD_SIZE  result value.
- reg_write0_o  out  1  write port 0 enable.
- dest0_o  out  PW  write port 0 destination.
- word0_o  out  WORD_SIZE  write port 0 data.
- reg_write1_o  out  1  write port 1 enable.
- dest1_o  out  PW  write port 1 destination.
- word1_o  out  WORD_SIZE  write port 1 data.
- pending_o  out  1  any source FIFO non-empty.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, rr_ptr = 0, reg_write0_o = reg_write1_o = 0, dest*_o = 0, word*_o = 0, pending_o = 0. res_ready{s}_o = 1 after reset.
- Reset mid-operation discards all buffered results. No partial write is emitted after reset deasserts.
- Handshake:
  - Transfer on posedge when res_valid{s}_i && res_ready{s}_o.
  - res_ready{s}_o = (count_s < FIFO_DEPTH), driven from registered count only; it does not depend on this cycle's pop.
  - Source holds dest and word stable while valid && !ready.
- A transfer with res_dest{s}_i == 0 is accepted (ready honoured) but not enqueued. Physical register 0 is never written.
- Arbitration, combinational on FIFO heads each cycle:
  - Scan sources in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - First non-empty source wins port 0. Next non-empty source wins port 1, unless its head dest equals the port-0 dest; that source is skipped this cycle and scanning continues.
  - Winners are popped at the posedge. Their head dest/word are registered into dest*_o/word*_o, and reg_write*_o is set for that cycle.
  - No grant: reg_write*_o = 0; dest*_o/word*_o hold previous values.
  - Only port 1 is never granted without port 0. If only one source is non-empty, port 0 is used and reg_write1_o = 0.
- rr_ptr update: after any grant, rr_ptr = (index of last granted source + 1) mod 3. Unchanged when idle.
- Latency:
  - Result accepted at edge N is visible on FIFO head after N.
  - Earliest output assertion is after edge N+1; the register file writes at edge N+2.
  - No bypass from input to output.
- Simultaneous push and pop on the same FIFO in one cycle is legal: count unchanged, order preserved.
- Push when full is impossible (ready = 0). Pop when empty never occurs.
- FIFO pointers wrap mod FIFO_DEPTH. Per-source ordering is strictly FIFO; there is no ordering guarantee across sources.
- pending_o = OR of (count_s != 0), registered-state derived.
- Throughput: sustained 2 writes/cycle when at least 2 sources are non-empty with distinct dests. A third source starves at most 1 cycle (round-robin fairness).

Test Plan:
- Reset, then single push src0 dest=5 word=0x11 at edge N. Expect reg_write0_o=1, dest0_o=5, word0_o=0x11 after N+1; reg_write1_o=0; pending_o back to 0 after N+1.
- Push src0 (dest 3, 0xA), src1 (dest 4, 0xB), src2 (dest 7, 0xC) in the same edge, rr_ptr=0.
  - Expect cycle 1: port0=3/0xA, port1=4/0xB.
  - Expect cycle 2: port0=7/0xC only.
  - rr_ptr ends at 0.
- Same-dest conflict: src1 and src2 both dest 9 (0x1, 0x2), rr_ptr=1. Expect port0=9/0x1 with reg_write1_o=0, then next cycle port0=9/0x2.
- Backpressure: hold res_valid0_i=1 with new data each cycle while src1/src2 are also streaming.
  - Expect res_ready0_o=0 once count reaches FIFO_DEPTH.
  - No data lost or duplicated; src0 outputs appear in push order.
- dest=0 push on src2 with word 0xFF: expect handshake completes, no reg_write*_o assertion, pending_o stays 0.
- Assert rst_i asynchronously mid-stream with 2 entries per FIFO. Expect all outputs 0 immediately, all ready=1 after release, and no stale writes afterwards.
